// File: rtl/count_stream_checker_pkg.sv
// Shared types and constants for the packed counter-word stream checker.
package count_stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam int unsigned ERR_REP  = 0;
  localparam int unsigned ERR_ALN  = 1;
  localparam int unsigned ERR_STEP = 2;

  localparam int unsigned HI_LSB  = 16;
  localparam int unsigned MID_LSB = 8;
  localparam int unsigned LO_LSB  = 0;

endpackage

// File: rtl/count_word_check.sv
// Combinational consistency checks on one counter word against its predecessor.
module count_word_check
  import count_stream_checker_pkg::*;
(
  input  logic [31:0] cur_w,
  input  logic [31:0] prev_w,
  input  logic        prev_d,
  output logic        rep_err,
  output logic        aln_err,
  output logic        step_err
);

  logic [15:0] cur_hi;
  logic [15:0] prev_hi;
  logic [15:0] exp_hi;

  always_comb begin
    cur_hi   = cur_w[HI_LSB +: 16];
    prev_hi  = prev_w[HI_LSB +: 16];
    // 16-bit arithmetic makes both wrap directions legal steps
    exp_hi   = prev_d ? (prev_hi + 16'd1) : (prev_hi - 16'd1);
    rep_err  = (cur_w[MID_LSB +: 8] != cur_w[LO_LSB +: 8]);
    aln_err  = (cur_w[HI_LSB +: 8] != cur_w[LO_LSB +: 8]);
    step_err = (cur_hi != exp_hi);
  end

endmodule

// File: rtl/count_stream_checker.sv
// Monitors the packed counter bus: samples each word, checks it, and runs
// an acquire/lock/fault state machine with sticky flags and a saturating error count.
module count_stream_checker
  import count_stream_checker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERRW       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            direction,
  input  logic [31:0]     count3,
  input  logic            clear,
  output logic            locked,
  output logic            fault,
  output logic            err_pulse,
  output logic [2:0]      err_code,
  output logic [ERRW-1:0] err_count
);

  logic [31:0]     cur_w_q, cur_w_d, prev_w_q, prev_w_d;
  logic            cur_d_q, cur_d_d, prev_d_q, prev_d_d;
  logic            cur_v_q, cur_v_d, have_prev_q, have_prev_d;
  state_e          state_q, state_d;
  logic [7:0]      good_run_q, good_run_d;
  logic            err_pulse_q, err_pulse_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  logic       rep_err, aln_err, step_err;
  logic [2:0] errs;
  logic       any_err;

  count_word_check u_check (
    .cur_w    (cur_w_q),
    .prev_w   (prev_w_q),
    .prev_d   (prev_d_q),
    .rep_err  (rep_err),
    .aln_err  (aln_err),
    .step_err (step_err)
  );

  always_comb begin
    errs           = '0;
    errs[ERR_REP]  = rep_err;
    errs[ERR_ALN]  = aln_err;
    errs[ERR_STEP] = step_err;
    errs           = errs & {3{have_prev_q}};
    any_err        = |errs;

    cur_w_d     = count3;
    cur_d_d     = direction;
    prev_w_d    = cur_w_q;
    prev_d_d    = cur_d_q;
    cur_v_d     = 1'b1;
    have_prev_d = cur_v_q;

    state_d     = state_q;
    good_run_d  = good_run_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;

    if (clear) begin
      err_count_d = '0;
      err_code_d  = '0;
      good_run_d  = '0;
      if (state_q != IDLE) state_d = SYNC;
    end else if (have_prev_q) begin
      unique case (state_q)
        // The first checked edge already counts toward the lock run
        IDLE, SYNC: begin
          state_d = SYNC;
          if (any_err) begin
            good_run_d = '0;
          end else begin
            good_run_d = good_run_q + 8'd1;
            if (good_run_d == 8'(LOCK_COUNT)) state_d = LOCKED;
          end
        end
        LOCKED, FAULT: begin
          if (any_err) begin
            state_d     = FAULT;
            err_pulse_d = 1'b1;
            err_code_d  = err_code_q | errs;
            if (err_count_q != '1) err_count_d = err_count_q + ERRW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_w_q     <= '0;
      cur_d_q     <= 1'b0;
      prev_w_q    <= '0;
      prev_d_q    <= 1'b0;
      cur_v_q     <= 1'b0;
      have_prev_q <= 1'b0;
      state_q     <= IDLE;
      good_run_q  <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      err_count_q <= '0;
    end else begin
      cur_w_q     <= cur_w_d;
      cur_d_q     <= cur_d_d;
      prev_w_q    <= prev_w_d;
      prev_d_q    <= prev_d_d;
      cur_v_q     <= cur_v_d;
      have_prev_q <= have_prev_d;
      state_q     <= state_d;
      good_run_q  <= good_run_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign fault     = (state_q == FAULT);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker: scoreboard of per-edge expectations
// plus literal spot checks, run on a 16-bit and a 2-bit error-counter instance.
module tb_count_stream_checker;

  localparam int unsigned LOCK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        direction;
  logic [31:0] count3;
  logic        clear;

  logic        locked0, fault0, pulse0;
  logic [2:0]  code0;
  logic [15:0] cnt0;
  logic        locked1, fault1, pulse1;
  logic [2:0]  code1;
  logic [1:0]  cnt1;

  count_stream_checker #(.LOCK_COUNT(LOCK), .ERRW(16)) dut (
    .clk(clk), .reset(reset), .direction(direction), .count3(count3), .clear(clear),
    .locked(locked0), .fault(fault0), .err_pulse(pulse0), .err_code(code0), .err_count(cnt0)
  );

  count_stream_checker #(.LOCK_COUNT(LOCK), .ERRW(2)) dut2 (
    .clk(clk), .reset(reset), .direction(direction), .count3(count3), .clear(clear),
    .locked(locked1), .fault(fault1), .err_pulse(pulse1), .err_code(code1), .err_count(cnt1)
  );

  always #5 clk = ~clk;

  // Reference sample stage feeding the shared word checker
  logic [31:0] m_cur_w, m_prev_w;
  logic        m_cur_d, m_prev_d, m_cur_v, m_have_prev;
  logic        r_rep, r_aln, r_step;

  count_word_check u_ref (
    .cur_w(m_cur_w), .prev_w(m_prev_w), .prev_d(m_prev_d),
    .rep_err(r_rep), .aln_err(r_aln), .step_err(r_step)
  );

  typedef struct {
    int          st;     // 0 idle, 1 sync, 2 locked, 3 fault
    int unsigned gr;
    bit          pulse;
    logic [2:0]  code;
    int unsigned cnt;
  } fsm_t;

  typedef struct {
    fsm_t a;
    fsm_t b;
  } exp_t;

  fsm_t        f0, f1;
  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned edge_cnt = 0;
  int unsigned lock_edge = 0;
  int unsigned pulses0 = 0;
  int unsigned pulses1 = 0;
  logic [15:0] v;
  logic        dir;

  function automatic fsm_t fsm_next(fsm_t f, bit clr, bit hp, logic [2:0] e, int unsigned maxc);
    fsm_t n = f;
    n.pulse = 1'b0;
    if (clr) begin
      n.cnt  = 0;
      n.code = 3'b000;
      n.gr   = 0;
      if (f.st != 0) n.st = 1;
    end else if (hp) begin
      if (f.st <= 1) begin
        n.st = 1;
        n.gr = (e != 3'b000) ? 0 : f.gr + 1;
        if (n.gr == LOCK) n.st = 2;
      end else if (e != 3'b000) begin
        n.st    = 3;
        n.pulse = 1'b1;
        n.code  = f.code | e;
        if (n.cnt < maxc) n.cnt = n.cnt + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    f0 = '{st: 0, gr: 0, pulse: 1'b0, code: 3'b000, cnt: 0};
    f1 = f0;
    m_cur_w = '0; m_prev_w = '0; m_cur_d = 1'b0; m_prev_d = 1'b0;
    m_cur_v = 1'b0; m_have_prev = 1'b0;
    sb.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d0"}, {locked0, fault0, pulse0, code0, cnt0}, 32'd0);
    chk({tag, "_d1"}, {locked1, fault1, pulse1, code1, cnt1}, 32'd0);
  endtask

  // Drive one word, predict the next edge, then compare after that edge
  task automatic step(input logic [31:0] w, input logic d, input logic clr);
    logic [2:0] e;
    exp_t x;
    count3    = w;
    direction = d;
    clear     = clr;
    e  = {r_step, r_aln, r_rep} & {3{m_have_prev}};
    f0 = fsm_next(f0, clr, m_have_prev, e, 32'd65535);
    f1 = fsm_next(f1, clr, m_have_prev, e, 32'd3);
    m_have_prev = m_cur_v;
    m_cur_v     = 1'b1;
    m_prev_w    = m_cur_w;
    m_prev_d    = m_cur_d;
    m_cur_w     = w;
    m_cur_d     = d;
    x.a = f0;
    x.b = f1;
    sb.push_back(x);
    @(negedge clk);
    edge_cnt++;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("d0_locked", 32'(locked0), 32'(x.a.st == 2));
      chk("d0_fault",  32'(fault0),  32'(x.a.st == 3));
      chk("d0_pulse",  32'(pulse0),  32'(x.a.pulse));
      chk("d0_code",   32'(code0),   32'(x.a.code));
      chk("d0_count",  32'(cnt0),    x.a.cnt);
      chk("d1_locked", 32'(locked1), 32'(x.b.st == 2));
      chk("d1_fault",  32'(fault1),  32'(x.b.st == 3));
      chk("d1_pulse",  32'(pulse1),  32'(x.b.pulse));
      chk("d1_code",   32'(code1),   32'(x.b.code));
      chk("d1_count",  32'(cnt1),    x.b.cnt);
    end
    if (pulse0) pulses0++;
    if (pulse1) pulses1++;
    if (locked0 && lock_edge == 0) lock_edge = edge_cnt;
  endtask

  function automatic logic [31:0] word(input logic [15:0] h);
    return {h, h[7:0], h[7:0]};
  endfunction

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step(word(v), dir, 1'b0);
      v = dir ? v + 16'd1 : v - 16'd1;
    end
  endtask

  // Hi field skips one value: a single step error with consistent bytes
  task automatic jump();
    v = v + 16'd1;
    run(1);
  endtask

  task automatic release_reset();
    model_reset();
    reset     = 1'b1;
    edge_cnt  = 0;
    lock_edge = 0;
  endtask

  initial begin
    int unsigned p;
    reset = 1'b0; direction = 1'b0; count3 = '0; clear = 1'b0;
    v = 16'h0000; dir = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");

    // Acquire from 0 counting up
    release_reset();
    run(8);
    chk("first_lock_edge", lock_edge, 32'd6);
    chk("first_lock_errcnt", 32'(cnt0), 32'd0);

    // Restart near the top and cross both wrap points
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_all_zero("reset_restart");
    @(negedge clk);
    v = 16'hFFF8; dir = 1'b1;
    release_reset();
    run(12);
    dir = 1'b0;
    run(8);
    chk("wrap_locked", 32'(locked0), 32'd1);
    chk("wrap_errcnt", 32'(cnt0), 32'd0);

    // Corrupt the byte fields of one word while locked
    dir = 1'b1;
    for (int i = 0; i < 100 && v != 16'h0012; i++) run(1);
    p = pulses0;
    step(32'h0012_1213, 1'b1, 1'b0);
    v = 16'h0013;
    run(3);
    chk("inject_pulses", pulses0 - p, 32'd1);
    chk("inject_fault", 32'(fault0), 32'd1);
    chk("inject_code", 32'(code0), 32'h3);
    chk("inject_count", 32'(cnt0), 32'd1);

    // Three step errors while in fault
    for (int i = 0; i < 3; i++) begin
      jump();
      run(2);
    end
    chk("fault_count", 32'(cnt0), 32'd4);
    chk("fault_code", 32'(code0), 32'h7);
    chk("fault_count_sat2", 32'(cnt1), 32'd3);

    // Clear and re-acquire
    step(word(v), dir, 1'b1);
    v = v + 16'd1;
    chk("clear_count", 32'(cnt0), 32'd0);
    chk("clear_code", 32'(code0), 32'd0);
    chk("clear_fault", 32'(fault0), 32'd0);
    run(3);
    chk("clear_relock_early", 32'(locked0), 32'd0);
    run(1);
    chk("clear_relock", 32'(locked0), 32'd1);

    // Clear on the same edge that evaluates a corrupted word
    p = pulses0;
    step({v, v[7:0] ^ 8'h01, v[7:0]}, dir, 1'b0);
    v = v + 16'd1;
    step(word(v), dir, 1'b1);
    v = v + 16'd1;
    run(4);
    chk("clr_err_pulses", pulses0 - p, 32'd0);
    chk("clr_err_count", 32'(cnt0), 32'd0);
    chk("clr_err_relock", 32'(locked0), 32'd1);

    // Saturation of the 2-bit counter: one error to fault, then five more
    step({v, v[7:0] ^ 8'h01, v[7:0]}, dir, 1'b0);
    v = v + 16'd1;
    run(2);
    p = pulses1;
    for (int i = 0; i < 5; i++) begin
      jump();
      run(2);
    end
    chk("sat_pulses", pulses1 - p, 32'd5);
    chk("sat_count2", 32'(cnt1), 32'd3);
    chk("sat_count16", 32'(cnt0), 32'd6);

    // Asynchronous reset mid-run, then re-acquisition
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    release_reset();
    run(8);
    chk("reacquire_lock_edge", lock_edge, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
